// File: rtl/timer_pkg.sv
// Shared constants for the timer: bus widths, register offsets, CTRL bit indices.
package timer_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Register select, taken from address bits [3:2]
  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_COUNT    = 2'd1;
  localparam logic [1:0] REG_COMPARE  = 2'd2;
  localparam logic [1:0] REG_PRESCALE = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;

endpackage

// File: rtl/timer.sv
// Memory-mapped timer: prescaler plus up-counter with compare match,
// sticky pending flag and a level interrupt gated by IE.
module timer
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESC_RESET = 32'd49
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              int_o
);

  logic        en;
  logic        ie;
  logic        pend;
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] prescale;
  logic [31:0] presc_cnt;

  logic        we_ctrl;
  logic        we_count;
  logic        we_compare;
  logic        we_prescale;
  logic        tick;
  logic        match;

  // Only bits [3:2] select a register; the rest of the address is decoded upstream.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr_i[ADDR_W-1:4], wr_addr_i[1:0],
                              rd_addr_i[ADDR_W-1:4], rd_addr_i[1:0]};

  assign we_ctrl     = wr_en_i && (wr_addr_i[3:2] == REG_CTRL);
  assign we_count    = wr_en_i && (wr_addr_i[3:2] == REG_COUNT);
  assign we_compare  = wr_en_i && (wr_addr_i[3:2] == REG_COMPARE);
  assign we_prescale = wr_en_i && (wr_addr_i[3:2] == REG_PRESCALE);

  // Tick and match depend only on registered state, so a COMPARE write in a
  // tick cycle is seen from the next tick onward.
  assign tick  = en && (presc_cnt == prescale);
  assign match = tick && (count == compare);

  // CTRL: EN/IE loaded by write; PEND set on match, write-1-to-clear, set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en   <= 1'b0;
      ie   <= 1'b0;
      pend <= 1'b0;
    end else begin
      if (we_ctrl) begin
        en <= wr_data_i[CTRL_EN];
        ie <= wr_data_i[CTRL_IE];
      end
      if (match) begin
        pend <= 1'b1;
      end else if (we_ctrl && wr_data_i[CTRL_PEND]) begin
        pend <= 1'b0;
      end
    end
  end

  // Prescale counter: runs while enabled, restarts on tick or PRESCALE write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= 32'd0;
    end else if (we_prescale || tick) begin
      presc_cnt <= 32'd0;
    end else if (en) begin
      presc_cnt <= presc_cnt + 32'd1;
    end
  end

  // COUNT: a bus write overrides (and swallows) a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (we_count) begin
      count <= wr_data_i;
    end else if (match) begin
      count <= 32'd0;
    end else if (tick) begin
      count <= count + 32'd1;
    end
  end

  // COMPARE and PRESCALE configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      compare  <= 32'hFFFF_FFFF;
      prescale <= PRESC_RESET;
    end else begin
      if (we_compare) begin
        compare <= wr_data_i;
      end
      if (we_prescale) begin
        prescale <= wr_data_i;
      end
    end
  end

  // Zero-latency read mux.
  always_comb begin
    rd_data_o = '0;
    case (rd_addr_i[3:2])
      REG_CTRL:     rd_data_o = {29'd0, pend, ie, en};
      REG_COUNT:    rd_data_o = count;
      REG_COMPARE:  rd_data_o = compare;
      REG_PRESCALE: rd_data_o = prescale;
      default:      rd_data_o = '0;
    endcase
  end

  assign int_o = pend & ie;

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for the timer: directed scenarios plus randomized
// enable/disable runs compared against an arithmetic period model.
module tb_timer;
  import timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        int_o;

  int checks = 0;
  int errors = 0;

  timer #(.PRESC_RESET(32'd49)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data),
    .int_o     (int_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // All tasks are entered and left just after a falling edge.
  task automatic bus_wr(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] junk;
    junk    = $urandom();
    wr_en   = 1'b1;
    wr_addr = {junk[31:4], r, junk[1:0]};
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] r, output logic [31:0] d);
    logic [31:0] junk;
    junk    = $urandom();
    rd_addr = {junk[31:4], r, junk[1:0]};
    #1;
    d = rd_data;
  endtask

  task automatic do_reset();
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    bus_rd(REG_CTRL, d);     checks++; if (d !== 32'd0)        begin errors++; $display("FAIL reset_ctrl got %h want %h", d, 32'd0); end
    bus_rd(REG_COUNT, d);    checks++; if (d !== 32'd0)        begin errors++; $display("FAIL reset_count got %h want %h", d, 32'd0); end
    bus_rd(REG_COMPARE, d);  checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_compare got %h want ffffffff", d); end
    bus_rd(REG_PRESCALE, d); checks++; if (d !== 32'd49)       begin errors++; $display("FAIL reset_prescale got %h want %h", d, 32'd49); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", int_o); end
    bus_wr(REG_CTRL, 32'hFFFF_FFF8);
    bus_rd(REG_CTRL, d);     checks++; if (d !== 32'd0)        begin errors++; $display("FAIL ctrl_unused_bits got %h want %h", d, 32'd0); end
  endtask

  task automatic test_basic_period();
    logic [31:0] d;
    do_reset();
    bus_wr(REG_PRESCALE, 32'd0);
    bus_wr(REG_COMPARE, 32'd3);
    bus_wr(REG_CTRL, 32'h3);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL basic_count_e0 got %h want 0", d); end
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        bus_rd(REG_COUNT, d);
        checks++; if (d !== 32'(k)) begin errors++; $display("FAIL basic_count rep%0d got %h want %h", rep, d, 32'(k)); end
      end
      @(negedge clk);
      bus_rd(REG_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL basic_wrap rep%0d got %h want 0", rep, d); end
      bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd7) begin errors++; $display("FAIL basic_pend rep%0d got %h want 7", rep, d); end
      checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL basic_int rep%0d got %b want 1", rep, int_o); end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d;
    int found;
    do_reset();
    bus_wr(REG_PRESCALE, 32'd49);
    bus_wr(REG_COMPARE, 32'd9);
    bus_wr(REG_CTRL, 32'h3);
    found = 0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (int_o === 1'b1) begin found = n; break; end
    end
    checks++; if (found != 500) begin errors++; $display("FAIL prescale_period got %0d want 500", found); end

    // Pause mid-run: EN cleared at edge 201, set again at edge 302.
    do_reset();
    bus_wr(REG_COMPARE, 32'd9);
    bus_wr(REG_CTRL, 32'h3);
    repeat (200) @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL prescale_count200 got %h want 4", d); end
    bus_wr(REG_CTRL, 32'h2);
    repeat (100) @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd4) begin errors++; $display("FAIL prescale_frozen got %h want 4", d); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL prescale_frozen_int got %b want 0", int_o); end
    bus_wr(REG_CTRL, 32'h3);
    found = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (int_o === 1'b1) begin found = n; break; end
    end
    checks++; if (found != 299) begin errors++; $display("FAIL prescale_resume got %0d want 299", found); end
  endtask

  task automatic test_clear_collision();
    logic [31:0] d;
    do_reset();
    bus_wr(REG_PRESCALE, 32'd0);
    bus_wr(REG_COMPARE, 32'd3);
    bus_wr(REG_CTRL, 32'h3);
    repeat (7) @(negedge clk);
    bus_wr(REG_CTRL, 32'h7);
    bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd7) begin errors++; $display("FAIL collide_pend got %h want 7", d); end
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL collide_int got %b want 1", int_o); end
    bus_wr(REG_CTRL, 32'h7);
    bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd3) begin errors++; $display("FAIL clear_pend got %h want 3", d); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL clear_int got %b want 0", int_o); end
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd1) begin errors++; $display("FAIL clear_count got %h want 1", d); end
  endtask

  task automatic test_count_write();
    logic [31:0] d;
    do_reset();
    bus_wr(REG_PRESCALE, 32'd0);
    bus_wr(REG_CTRL, 32'h3);
    bus_wr(REG_COUNT, 32'h10);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'h10) begin errors++; $display("FAIL cntwr_win got %h want 10", d); end
    @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'h11) begin errors++; $display("FAIL cntwr_next got %h want 11", d); end
    bus_wr(REG_COMPARE, 32'd5);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'h12) begin errors++; $display("FAIL cntwr_above got %h want 12", d); end
    bus_wr(REG_COUNT, 32'hFFFF_FFFE);
    @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL cntwr_max got %h want ffffffff", d); end
    @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL cntwr_wrap got %h want 0", d); end
    bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd3) begin errors++; $display("FAIL cntwr_nopend got %h want 3", d); end
    repeat (5) @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd5) begin errors++; $display("FAIL cntwr_reach got %h want 5", d); end
    @(negedge clk);
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL cntwr_match got %h want 0", d); end
    bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd7) begin errors++; $display("FAIL cntwr_pend got %h want 7", d); end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    bus_wr(REG_PRESCALE, 32'd0);
    bus_wr(REG_COMPARE, 32'd1);
    bus_wr(REG_CTRL, 32'h3);
    repeat (2) @(negedge clk);
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL arst_pre_int got %b want 1", int_o); end
    @(posedge clk);
    #5;
    rst_n = 1'b0;
    #1;
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL arst_int got %b want 0", int_o); end
    bus_rd(REG_CTRL, d);  checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_ctrl got %h want 0", d); end
    bus_rd(REG_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL arst_count got %h want 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus_rd(REG_CTRL, d);     checks++; if (d !== 32'd0)        begin errors++; $display("FAIL arst_post_ctrl got %h want 0", d); end
    bus_rd(REG_COUNT, d);    checks++; if (d !== 32'd0)        begin errors++; $display("FAIL arst_post_count got %h want 0", d); end
    bus_rd(REG_COMPARE, d);  checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL arst_post_compare got %h want ffffffff", d); end
    bus_rd(REG_PRESCALE, d); checks++; if (d !== 32'd49)       begin errors++; $display("FAIL arst_post_prescale got %h want 31", d); end
  endtask

  // Random EN toggling: the model only tracks how many clock edges saw EN=1.
  // From that, COUNT = (enabled/(P+1)) mod (C+1) and PEND = enabled >= (C+1)(P+1).
  task automatic test_random();
    logic [31:0] d;
    int p, c, en_cycles, exp_cnt;
    logic m_en, m_en_prev, exp_int;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      p = $urandom_range(0, 4);
      c = $urandom_range(0, 6);
      bus_wr(REG_CTRL, 32'h4);
      bus_wr(REG_PRESCALE, 32'(p));
      bus_wr(REG_COMPARE, 32'(c));
      bus_wr(REG_COUNT, 32'd0);
      bus_wr(REG_CTRL, 32'h3);
      m_en = 1'b1;
      en_cycles = 0;
      for (int i = 0; i < 150; i++) begin
        m_en_prev = m_en;
        if ($urandom_range(0, 7) == 0) begin
          m_en = !m_en;
          bus_wr(REG_CTRL, {29'd0, 1'b0, 1'b1, m_en});
        end else begin
          @(negedge clk);
        end
        if (m_en_prev) en_cycles++;
        exp_cnt = (en_cycles / (p + 1)) % (c + 1);
        exp_int = (en_cycles >= (c + 1) * (p + 1));
        bus_rd(REG_COUNT, d);
        checks++; if (d !== 32'(exp_cnt)) begin errors++; $display("FAIL rand_count t%0d i%0d P=%0d C=%0d got %h want %h", t, i, p, c, d, 32'(exp_cnt)); end
        checks++; if (int_o !== exp_int) begin errors++; $display("FAIL rand_int t%0d i%0d P=%0d C=%0d got %b want %b", t, i, p, c, int_o, exp_int); end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    @(negedge clk);
    test_reset();
    test_basic_period();
    test_prescale();
    test_clear_collision();
    test_count_write();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
